// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad column scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        CAPTURE,
        WAIT_RELEASE
    } scan_state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    // Returns {valid, idx}; valid is set only when exactly one bit of v is high.
    function automatic logic [2:0] onehot_to_idx(input logic [3:0] v);
        logic [2:0] r;
        r = 3'b000;
        case (v)
            4'b0001: r = 3'b100;
            4'b0010: r = 3'b101;
            4'b0100: r = 3'b110;
            4'b1000: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous keypad rows.
module sync_2ff #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
    input  logic             clck_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
    always_ff @(posedge clck_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-drive and key-encode stage: walks the columns, freezes on a detect,
// encodes {row, col} and waits for release before scanning resumes.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 20000
) (
    input  logic       clck_i,
    input  logic       rst_i,
    input  logic [3:0] filas_i,
    input  logic       deteccion_i,
    output logic [3:0] columnas_o,
    output logic [3:0] tecla_o,
    output logic       tecla_valid_o
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] BLANK_LIM  = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [3:0]          tecla_q, tecla_d;
    logic                tecla_valid_q, tecla_valid_d;
    logic [NUM_ROWS-1:0] filas_s;
    logic [2:0]          row_hit;

    sync_2ff #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ({NUM_ROWS{1'b1}})
    ) u_sync_filas (
        .clck_i (clck_i),
        .rst_i  (rst_i),
        .d_i    (filas_i),
        .q_o    (filas_s)
    );

    // Rows are active-low; a zero or multi-row pattern yields valid=0 and is dropped.
    assign row_hit = onehot_to_idx(~filas_s);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_idx_d     = col_idx_q;
        tecla_d       = tecla_q;
        tecla_valid_d = 1'b0;

        unique case (state_q)
            SCAN: begin
                // Detect wins over the column advance so a press on the last dwell cycle is kept.
                if (cnt_q >= BLANK_LIM && deteccion_i) begin
                    state_d = CAPTURE;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (row_hit[2]) begin
                    tecla_d       = {row_hit[1:0], col_idx_q};
                    tecla_valid_d = 1'b1;
                end
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!deteccion_i) begin
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 1'b1;
                    state_d   = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= SCAN;
            cnt_q         <= '0;
            col_idx_q     <= '0;
            tecla_q       <= 4'h0;
            tecla_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_idx_q     <= col_idx_d;
            tecla_q       <= tecla_d;
            tecla_valid_q <= tecla_valid_d;
        end
    end

    assign columnas_o    = ~(4'b0001 << col_idx_q);
    assign tecla_o       = tecla_q;
    assign tecla_valid_o = tecla_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with short dwell/blank settings.
module tb_keypad_scanner;

    localparam int DWELL = 8;
    localparam int BLANK = 3;

    logic       clck_i = 1'b0;
    logic       rst_i;
    logic [3:0] filas_i;
    logic       deteccion_i;
    logic [3:0] columnas_o;
    logic [3:0] tecla_o;
    logic       tecla_valid_o;

    keypad_scanner #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clck_i        (clck_i),
        .rst_i         (rst_i),
        .filas_i       (filas_i),
        .deteccion_i   (deteccion_i),
        .columnas_o    (columnas_o),
        .tecla_o       (tecla_o),
        .tecla_valid_o (tecla_valid_o)
    );

    always #5 clck_i = ~clck_i;

    typedef struct {
        int         col;
        logic [3:0] filas;
        int         det_at;
        int         det_len;
        bit         capture;
        bit         pulse;
        logic [3:0] code;
    } vec_t;

    int         checks         = 0;
    int         failures       = 0;
    int         cyc            = 0;
    int         pulses         = 0;
    int         last_pulse_cyc = -1;
    int         det_cyc        = 0;
    logic       prev_valid     = 1'b0;
    logic [3:0] model_tecla    = 4'h0;
    logic [3:0] sb_q[$];
    vec_t       vecs[7];

    function automatic logic [3:0] col_drive(input int c);
        case (c % 4)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and scoring any valid pulse.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clck_i);
            cyc++;
            if (tecla_valid_o) begin
                pulses++;
                last_pulse_cyc = cyc;
                check("pulse_width", 32'(prev_valid), 32'(0));
                check("pulse_expected", 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) check("pulse_code", 32'(tecla_o), 32'(sb_q.pop_front()));
            end
            prev_valid = tecla_valid_o;
        end
    endtask

    // Returns on the first cycle column c is driven (dwell counter at 0).
    task automatic wait_col(input int c);
        for (int i = 0; i < 64 && columnas_o == col_drive(c); i++) step(1);
        for (int i = 0; i < 64 && columnas_o != col_drive(c); i++) step(1);
        check("wait_col", 32'(columnas_o), 32'(col_drive(c)));
    endtask

    initial begin
        vecs[0] = '{col: 1, filas: 4'b1011, det_at: 3, det_len: 10,  capture: 1'b1, pulse: 1'b1, code: 4'h9};
        vecs[1] = '{col: 3, filas: 4'b1110, det_at: 0, det_len: 3,   capture: 1'b0, pulse: 1'b0, code: 4'h0};
        vecs[2] = '{col: 0, filas: 4'b0011, det_at: 3, det_len: 4,   capture: 1'b1, pulse: 1'b0, code: 4'h0};
        vecs[3] = '{col: 3, filas: 4'b0111, det_at: 3, det_len: 100, capture: 1'b1, pulse: 1'b1, code: 4'hF};
        vecs[4] = '{col: 2, filas: 4'b1101, det_at: 5, det_len: 3,   capture: 1'b1, pulse: 1'b1, code: 4'h6};
        vecs[5] = '{col: 1, filas: 4'b1111, det_at: 4, det_len: 3,   capture: 1'b1, pulse: 1'b0, code: 4'h0};
        vecs[6] = '{col: 2, filas: 4'b1110, det_at: 7, det_len: 3,   capture: 1'b1, pulse: 1'b1, code: 4'h2};

        rst_i       = 1'b1;
        filas_i     = 4'hF;
        deteccion_i = 1'b0;
        step(2);
        check("reset_col", 32'(columnas_o), 32'(4'b1110));
        check("reset_tecla", 32'(tecla_o), 32'(0));
        check("reset_valid", 32'(tecla_valid_o), 32'(0));
        rst_i = 1'b0;

        for (int i = 1; i <= 40; i++) begin
            step(1);
            check("idle_col", 32'(columnas_o), 32'(col_drive((i / DWELL) % 4)));
        end

        foreach (vecs[k]) begin
            wait_col(vecs[k].col);
            filas_i = vecs[k].filas;
            step(vecs[k].det_at);
            deteccion_i = 1'b1;
            det_cyc     = cyc;
            if (vecs[k].pulse) begin
                sb_q.push_back(vecs[k].code);
                model_tecla = vecs[k].code;
            end
            step(vecs[k].det_len);
            if (vecs[k].capture) begin
                check("frozen_col", 32'(columnas_o), 32'(col_drive(vecs[k].col)));
                if (vecs[k].pulse) check("latency", 32'(last_pulse_cyc - det_cyc), 32'(2));
                deteccion_i = 1'b0;
                filas_i     = 4'hF;
                step(1);
                check("release_advance", 32'(columnas_o), 32'(col_drive(vecs[k].col + 1)));
            end else begin
                deteccion_i = 1'b0;
                filas_i     = 4'hF;
                step(DWELL - 1 - vecs[k].det_at - vecs[k].det_len);
                check("blank_hold", 32'(columnas_o), 32'(col_drive(vecs[k].col)));
                step(1);
                check("blank_advance", 32'(columnas_o), 32'(col_drive(vecs[k].col + 1)));
            end
            check("tecla_hold", 32'(tecla_o), 32'(model_tecla));
        end

        // Reset while in CAPTURE: the pending pulse and new code must never appear.
        wait_col(1);
        filas_i = 4'b0111;
        step(BLANK);
        deteccion_i = 1'b1;
        step(1);
        rst_i = 1'b1;
        #1;
        check("midrst_valid", 32'(tecla_valid_o), 32'(0));
        check("midrst_tecla", 32'(tecla_o), 32'(0));
        check("midrst_col", 32'(columnas_o), 32'(4'b1110));
        model_tecla = 4'h0;
        deteccion_i = 1'b0;
        filas_i     = 4'hF;
        step(2);
        rst_i = 1'b0;
        step(DWELL - 1);
        check("postrst_hold", 32'(columnas_o), 32'(4'b1110));
        step(1);
        check("postrst_advance", 32'(columnas_o), 32'(4'b1101));
        check("postrst_tecla", 32'(tecla_o), 32'(model_tecla));

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        check("pulse_count", 32'(pulses), 32'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
